// File: rtl/instruction_fetch_memory.sv
// Instruction memory with clear sequencer, valid/ready fetch port and program-load port.
// Optional IMEM_BOUNDS_CHECK_EN flags misaligned/out-of-range fetches and drops such loads.
module instruction_fetch_memory #(
   parameter int MEM_DEPTH    = 1024,
   parameter int FETCH_WIDTH  = 1,
   parameter int READ_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      init_done,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_addr,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [32*FETCH_WIDTH-1:0] resp_data,
   output logic [31:0]               resp_addr,
   output logic                      resp_err,
   input  logic                      flush,
   input  logic                      load_en,
   input  logic [31:0]               load_addr,
   input  logic [31:0]               load_data
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int DW = 32 * FETCH_WIDTH;
   localparam int FD = READ_LATENCY + 1;
   localparam int PW = $clog2(FD);
   localparam int CW = $clog2(FD + 1);

   typedef enum logic {CLEAR, READY} state_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [31:0]   addr;
      logic          err;
   } ent_t;

   state_t         state;
   logic [AW-1:0]  clr_idx;
   logic [31:0]    mem [MEM_DEPTH];
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  count;
   ent_t           fifo [FD];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   ent_t           st_ent;
   ent_t           fin;
   ent_t           rd_ent;
   logic           fin_v;
   logic           accept;
   logic           deliver;
   logic           ld_ok;
   logic [AW-1:0]  req_idx;
   logic [AW-1:0]  ld_idx;
   logic [DW-1:0]  st_data;
   logic           st_err;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
   endfunction

   assign req_idx = req_addr[AW+1:2];
   assign ld_idx  = load_addr[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
   logic unused_bits;
   assign unused_bits = ^load_addr[1:0];
   assign ld_ok = ~|load_addr[31:AW+2];
`else
   logic unused_bits;
   assign unused_bits = ^{load_addr[31:AW+2], load_addr[1:0],
                          req_addr[31:AW+2], req_addr[1:0]};
   assign ld_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         init_done <= 1'b0;
      end else if (state == CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == AW'(MEM_DEPTH - 1)) begin
            state     <= READY;
            init_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[clr_idx] <= '0;
      else if (!reset && load_en && ld_ok)
         mem[ld_idx] <= load_data;
   end

   // Sampled at acceptance, so a same-edge load is not visible (read-first).
   always_comb begin
      st_data = '0;
      st_err  = 1'b0;
      for (int k = 0; k < FETCH_WIDTH; k++)
         st_data[32*k +: 32] = mem[req_idx + AW'(k)];
`ifdef IMEM_BOUNDS_CHECK_EN
      st_err = (|req_addr[1:0]) | (|req_addr[31:AW+2]);
      if (st_err)
         for (int k = 0; k < FETCH_WIDTH; k++)
            st_data[32*k +: 32] = 32'h0000_0013;
`endif
   end

   assign st_ent = '{data: st_data, addr: req_addr, err: st_err};

   assign req_ready  = init_done & ~flush & (inflight < CW'(FD));
   assign accept     = req_valid & req_ready;
   assign resp_valid = (count != '0);
   assign deliver    = resp_valid & resp_ready;

   generate
      if (READ_LATENCY == 1) begin : g_direct
         assign fin   = st_ent;
         assign fin_v = accept;
      end else begin : g_pipe
         ent_t                    pe [READ_LATENCY-1];
         logic [READ_LATENCY-2:0] pv;

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               pv <= '0;
            end else begin
               pv[0] <= accept;
               for (int i = 1; i < READ_LATENCY - 1; i++)
                  pv[i] <= pv[i-1];
            end
            pe[0] <= st_ent;
            for (int i = 1; i < READ_LATENCY - 1; i++)
               pe[i] <= pe[i-1];
         end

         assign fin   = pe[READ_LATENCY-2];
         assign fin_v = pv[READ_LATENCY-2];
      end
   endgenerate

   // In-flight limit equals buffer depth, so the buffer cannot overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FD; i++)
            fifo[i] <= '0;
      end else if (fin_v && !flush) begin
         fifo[wr_ptr] <= fin;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
      end else begin
         if (fin_v)
            wr_ptr <= nxt(wr_ptr);
         if (deliver)
            rd_ptr <= nxt(rd_ptr);
         count    <= count + CW'(fin_v) - CW'(deliver);
         inflight <= inflight + CW'(accept) - CW'(deliver);
      end
   end

   assign rd_ent    = fifo[rd_ptr];
   assign resp_data = rd_ent.data;
   assign resp_addr = rd_ent.addr;
   assign resp_err  = rd_ent.err;

endmodule

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised instruction memory for the single-cycle and pipelined RISC-V cores, replacing the fixed 1024×32 asynchronous-read array. It adds a valid/ready fetch request port, configurable read latency, and multi-instruction fetch groups. It also provides a runtime program-load write port and a hardware clear sequencer, so no simulator file path is needed. It sits between the PC/fetch stage and the decode stage.

## Interface
- MEM_DEPTH, 1024, number of 32-bit words; power of two, ≥ 4·FETCH_WIDTH
- FETCH_WIDTH, 1, instructions returned per response; 1, 2 or 4
- READ_LATENCY, 1, cycles from request acceptance to response valid; 1..4
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- init_done  out  1  clear sequence finished; memory usable
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when valid&ready at clk edge
- req_addr  in  32  byte address of first instruction
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_data  out  32·FETCH_WIDTH  lane k (bits 32k+31:32k) = word at index (idx+k) mod MEM_DEPTH
- resp_addr  out  32  req_addr of the request this response answers
- resp_err  out  1  bounds/alignment error (see Configuration)
- flush  in  1  discard all in-flight and buffered responses
- load_en  in  1  program-load write strobe
- load_addr  in  32  byte address of write; word index = load_addr[log2(MEM_DEPTH)+1:2]
- load_data  in  32  word written

## Operation
- Word index idx = req_addr[log2(MEM_DEPTH)+1:2].
- Clear sequencer states: CLEAR → READY.
  - CLEAR: writes 0 to one word per cycle, index 0..MEM_DEPTH-1.
  - init_done=0, req_ready=0; load_en ignored.
  - After the last word is written, the sequencer enters READY and init_done=1.
- READY: requests are pipelined through READ_LATENCY stages into an output buffer of READ_LATENCY+1 entries.
  - In-flight counter = accepted requests not yet delivered (resp_valid&resp_ready).
  - req_ready = init_done & !flush & (inflight < READ_LATENCY+1).
  - Same-cycle accept and deliver leaves the count unchanged.
- Responses are delivered strictly in request order.
  - resp_data, resp_addr and resp_err stay stable while resp_valid=1 and resp_ready=0.
- Fetch-group wrap: lanes past MEM_DEPTH-1 wrap to index 0.
- Load port, READY only:
  - mem[load word index] ← load_data at the clk edge.
  - Read-first: a request accepted in the same cycle as a write to an overlapping word returns the old data.
  - Requests accepted after that edge return the new data.
- flush:
  - All in-flight and buffered entries are dropped at the edge; the counter goes to 0.
  - resp_valid=0 the next cycle.
  - req_ready=0 during the flush cycle, so no request is accepted then.
  - A load_en in the same cycle still writes.
- Reset mid-operation:
  - All in-flight and buffered entries are dropped; the counter goes to 0.
  - The sequencer returns to CLEAR and restarts at index 0.
  - Memory contents are re-zeroed.

## Timing
- Reset values: init_done=0, req_ready=0, resp_valid=0, resp_data=0, resp_addr=0, resp_err=0.
- Init: with reset deasserted from cycle 0, init_done=1 from cycle MEM_DEPTH onward. First request is accepted at the cycle-MEM_DEPTH edge.
- Latency: request accepted at edge N → resp_valid=1 in the cycle following edge N+READ_LATENCY-1 (READ_LATENCY=1: the cycle right after acceptance).
- Throughput: one request per cycle while resp_ready=1.
- Backpressure: with resp_ready=0, at most READ_LATENCY+1 requests are accepted, then req_ready=0. One cycle after resp_ready returns, req_ready=1 again.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined:
  - Triggers: req_addr[1:0]≠0, or req_addr ≥ 4·MEM_DEPTH.
  - Response: all lanes = 32'h00000013 (NOP), resp_err=1.
  - Such requests still occupy a pipeline slot and stay in order.
  - A load with out-of-range load_addr is discarded.
- Undefined:
  - Upper address bits and req_addr[1:0] are ignored; index wraps modulo MEM_DEPTH.
  - resp_err is tied 0; all loads write.

## Test plan
- Reset, then hold 2000 cycles with MEM_DEPTH=1024 → init_done rises exactly at cycle 1024. A request at 0x0 returns 0x00000000.
- Load 0x00500093 at 0x0 and 0x00A00113 at 0x4, then FETCH_WIDTH=2, READ_LATENCY=2, request 0x0 → after 2 cycles, resp_data=0x00A00113_00500093 and resp_addr=0.
- Back-to-back requests 0x0,0x4,0x8,0xC with resp_ready=0, READ_LATENCY=1 → only 2 accepted and req_ready=0. Release resp_ready → responses arrive in order, and the remaining two are accepted and returned.
- Request 0xFFC with FETCH_WIDTH=2 and MEM_DEPTH=1024 → lane0=mem[1023], lane1=mem[0].
- Flush with 3 requests in flight → resp_valid=0 next cycle, and none of the 3 responses ever appears. A new request to 0x8 returns mem[2].
- With IMEM_BOUNDS_CHECK_EN, request 0x2 and 0x1000 → data 0x00000013, resp_err=1. Without the macro, 0x1000 returns mem[0] and resp_err=0.
